multi_scanner_controller: RTL

MULTI_SCANNER_CONTROLLER -- requirements
Module: multi_scanner_controller

---
 rtl/multi_scanner_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multi_scanner_controller.sv
// Multi-scanner ping-pong collection controller: scanners collect in rotation, wake their
// successor to standby ahead of the handoff, and share a single transfer/flush path.
module multi_scanner_controller #(
  parameter int unsigned NUM_SCAN  = 2,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned STBY_LVL  = 8,
  parameter int unsigned XFER_LVL  = 9,
  parameter int unsigned FLUSH_CYC = 3,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startScan,
  input  logic                   startTransfer,
  output logic [NUM_SCAN-1:0]    transfer_me,
  output logic [NUM_SCAN-1:0]    go_to_standby,
  output logic [NUM_SCAN-1:0]    flush,
  output logic [4*NUM_SCAN-1:0]  state_o,
  output logic [CW*NUM_SCAN-1:0] fill_o,
  output logic                   overrun
);

  localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [CW-1:0]  FillOne   = CW'(1);
  localparam logic [CW-1:0]  FillStby  = CW'(STBY_LVL);
  localparam logic [CW-1:0]  FillXfer  = CW'(XFER_LVL);
  localparam logic [CW-1:0]  FillLast  = CW'(DEPTH - 1);
  localparam logic [CW-1:0]  FillFull  = CW'(DEPTH);
  localparam logic [FCW-1:0] FlushLast = FCW'(FLUSH_CYC - 1);

  typedef enum logic [3:0] {
    StLowPower     = 4'd0,
    StStandby      = 4'd1,
    StCollecting   = 4'd2,
    StIdle         = 4'd3,
    StTransferring = 4'd4,
    StFlushing     = 4'd5
  } state_e;

  state_e         state_q [NUM_SCAN];
  state_e         state_d [NUM_SCAN];
  logic [CW-1:0]  fill_q  [NUM_SCAN];
  logic [CW-1:0]  fill_d  [NUM_SCAN];
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic           overrun_q, overrun_d;

  logic [NUM_SCAN-1:0] gts, full_edge, wake, handoff, is_idle, is_stby, idle_sel;
  logic                all_low, busy, grant;

  always_comb begin
    all_low   = 1'b1;
    busy      = 1'b0;
    gts       = '0;
    full_edge = '0;
    is_idle   = '0;
    is_stby   = '0;
    for (int i = 0; i < NUM_SCAN; i++) begin
      if (state_q[i] != StLowPower) all_low = 1'b0;
      if (state_q[i] inside {StTransferring, StFlushing}) busy = 1'b1;
      gts[i]       = (state_q[i] == StCollecting) && (fill_q[i] == FillStby);
      full_edge[i] = (state_q[i] == StCollecting) && (fill_q[i] == FillLast);
      is_idle[i]   = (state_q[i] == StIdle);
      is_stby[i]   = (state_q[i] == StStandby);
    end
    // Bit j of these sees scanner j-1 (mod NUM_SCAN), i.e. its predecessor in the ring.
    wake     = {gts[NUM_SCAN-2:0], gts[NUM_SCAN-1]};
    handoff  = {full_edge[NUM_SCAN-2:0], full_edge[NUM_SCAN-1]};
    idle_sel = is_idle & (~is_idle + 1'b1);
    grant    = startTransfer & ~busy;
    // A handoff to a successor that is not ready to collect loses data.
    overrun_d = overrun_q | (|(handoff & ~is_stby));
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    for (int i = 0; i < NUM_SCAN; i++) begin
      state_d[i] = state_q[i];
      fill_d[i]  = fill_q[i];
      case (state_q[i])
        StLowPower: begin
          if (i == 0 && startScan && all_low) begin
            state_d[i] = StCollecting;
            fill_d[i]  = '0;
          end else if (wake[i]) begin
            state_d[i] = StStandby;
          end
        end
        StStandby: begin
          if (handoff[i]) begin
            state_d[i] = StCollecting;
            fill_d[i]  = '0;
          end
        end
        StCollecting: begin
          if (fill_q[i] >= FillLast) begin
            state_d[i] = StIdle;
            fill_d[i]  = FillFull;
          end else begin
            fill_d[i] = fill_q[i] + FillOne;
          end
        end
        StIdle: begin
          if (grant && idle_sel[i]) state_d[i] = StTransferring;
        end
        StTransferring: begin
          if (fill_q[i] <= FillOne) begin
            state_d[i]  = StFlushing;
            fill_d[i]   = '0;
            flush_cnt_d = '0;
          end else begin
            fill_d[i] = fill_q[i] - FillOne;
          end
        end
        StFlushing: begin
          if (flush_cnt_q >= FlushLast) begin
            state_d[i]  = StLowPower;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + FCW'(1);
          end
        end
        default: begin
          state_d[i] = StLowPower;
          fill_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SCAN; i++) begin
        state_q[i] <= StLowPower;
        fill_q[i]  <= '0;
      end
      flush_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SCAN; i++) begin
        state_q[i] <= state_d[i];
        fill_q[i]  <= fill_d[i];
      end
      flush_cnt_q <= flush_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_o     = '0;
    fill_o      = '0;
    transfer_me = '0;
    flush       = '0;
    for (int i = 0; i < NUM_SCAN; i++) begin
      state_o[4*i +: 4]  = state_q[i];
      fill_o[CW*i +: CW] = fill_q[i];
      transfer_me[i]     = (state_q[i] inside {StCollecting, StIdle}) && (fill_q[i] >= FillXfer);
      flush[i]           = (state_q[i] == StFlushing);
    end
    go_to_standby = gts;
    overrun       = overrun_q;
  end

endmodule
